// File: rtl/fifo_pkg.sv
// Shared FIFO geometry and arbiter state type.
// Imported by the write arbiter and its selector.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    // Must hold 0..FIFO_DEPTH inclusive.
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set req bit at or after ptr.
// Ports: req (vector), ptr (start index) -> valid, index.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   index
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst round-robin arbiter feeding one FIFO write port.
// Ports: clk, reset, req/req_data in, gnt out, fifo_full and
// fifo_counter in, write/data_in registered out, stall out.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic [FIFO_CNT_W-1:0]         fifo_counter,
    output logic                          write,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic                          stall
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;

    logic                  rr_valid;
    logic [PTR_W-1:0]      rr_idx;
    logic [PTR_W-1:0]      owner_inc;
    logic [FIFO_CNT_W:0]   occ;
    logic                  space;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .valid (rr_valid),
        .index (rr_idx)
    );

    // The registered write lands next cycle, so count it now.
    assign occ = {1'b0, fifo_counter}
               + {{FIFO_CNT_W{1'b0}}, write_q};
    assign space = ~fifo_full
                 & (occ < (FIFO_CNT_W + 1)'(FIFO_DEPTH));

    assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1))
                     ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        stall   = 1'b0;
        if (!reset) begin
            stall = (|req) & ~space;
            unique case (state_q)
                IDLE: begin
                    // A full burst leaves cnt at BURST_LEN: that
                    // IDLE cycle is the rest bubble, no arbitration.
                    if (cnt_q == CNT_W'(BURST_LEN)) begin
                        cnt_d = '0;
                    end else if (rr_valid && space) begin
                        gnt[rr_idx] = 1'b1;
                        owner_d     = rr_idx;
                        cnt_d       = CNT_W'(1);
                        state_d     = BURST;
                    end
                end
                BURST: begin
                    if (!req[owner_q]) begin
                        state_d = IDLE;
                        ptr_d   = owner_inc;
                    end else if (space) begin
                        gnt[owner_q] = 1'b1;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CNT_W'(BURST_LEN)) begin
                            state_d = IDLE;
                            ptr_d   = owner_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        write_d = |gnt;
        data_d  = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                data_d = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    assign write   = write_q;
    assign data_in = data_q;

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of write requesters.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, the maximum consecutive accepts per grant (legal range 2..16).
REQ-003 The block SHALL have the following ports, in this order:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  NUM_REQ  per-requester write request; held with data until accepted.
- req_data  input  NUM_REQ x FIFO_WIDTH  per-requester write word.
- gnt  output  NUM_REQ  one-hot accept strobe; req_data[i] is captured at the edge ending a cycle with gnt[i]=1.
- fifo_full  input  1  FIFO full flag.
- fifo_counter  input  FIFO_CNT_W  FIFO occupancy.
- write  output  1  registered FIFO write enable.
- data_in  output  FIFO_WIDTH  registered FIFO write word.
- stall  output  1  combinational; 1 when any req=1 but no word is accepted for lack of space.

Function
REQ-004 The FSM SHALL have two states: IDLE and BURST, with registered owner index, burst counter and round-robin pointer.
REQ-005 Space SHALL exist when fifo_full=0 and (fifo_counter + write) < FIFO_DEPTH, accounting for the in-flight registered write.
REQ-006 In IDLE with any req=1 and space available, the block SHALL assert gnt for the first requesting index at or after the pointer (wrapping modulo NUM_REQ), load owner, set the burst counter to 1 and enter BURST.
REQ-007 In BURST with req[owner]=1 and space available, the block SHALL assert gnt[owner] and increment the burst counter.
REQ-008 In BURST with req[owner]=1 and no space, the block SHALL assert no gnt, hold the counter and remain in BURST; other requesters SHALL NOT be granted.
REQ-009 The block SHALL return to IDLE with pointer = (owner+1) mod NUM_REQ when the counter reaches BURST_LEN on an accept, or when req[owner]=0 in BURST; no gnt SHALL be issued in that req[owner]=0 cycle.
REQ-010 Arbitration SHALL occur only in IDLE, giving exactly one bubble cycle between bursts.
REQ-011 gnt SHALL be combinational and at most one-hot; it SHALL never be asserted without space.
REQ-012 A word accepted in cycle N SHALL appear on write=1/data_in in cycle N+1 (latency 1); write SHALL be 0 in any cycle following a cycle with no gnt.
REQ-013 data_in SHALL hold its last value when write=0.

Reset
REQ-014 When reset=1 at a rising edge, the block SHALL set state=IDLE, pointer=0, owner=0, counter=0, write=0 and data_in=0, overriding any in-progress burst.
REQ-015 gnt and stall SHALL be 0 while reset=1.

Structure
REQ-016 Package fifo_pkg SHALL hold FIFO_WIDTH, FIFO_DEPTH, FIFO_CNT_W (able to represent 0..FIFO_DEPTH) and the state enum type.
REQ-017 Round-robin selection SHALL be a sub-module rr_select that is purely combinational (inputs: req vector, pointer; outputs: valid, index).
REQ-018 The target size is 120-400 lines of RTL, with the FSM, counters and output registers in fifo_write_arbiter.

Verification (NUM_REQ=4, BURST_LEN=4, FIFO_DEPTH=16)
REQ-019 Reset: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, write=0, data_in=0; the first grant after release goes to index 0.
REQ-020 Single requester: req[2] is held for 6 words (data 1..6) -> gnt[2] for 4 cycles, 1 bubble, then gnt[2] for 2 cycles; data_in sequence is 1..6, each 1 cycle after its gnt.
REQ-021 Fairness: req=4'b1111 is held continuously -> grant order 0x4, 1x4, 2x4, 3x4, 0x4, with one bubble between bursts.
REQ-022 Full: fifo_counter=15 with write=0 -> one accept; next cycle, counter=15 and write=1 -> no gnt and stall=1; counter drops to 14 with write=0 -> accept resumes.
REQ-023 Owner drop: req[1] is deasserted after 2 accepts while req[3]=1 -> IDLE, pointer=2, and the next cycle grants index 3.
REQ-024 Reset mid-burst: reset=1 after 2 accepts by requester 0 -> write=0 next cycle; after release, requester 0 is granted with counter restarting at 1.
